// File: rtl/linear_interpolator_pkg.sv
// Shared constants and FSM state type for the linear interpolator.
// Both the top level and the phase datapath import this package.
package linear_interpolator_pkg;

    localparam int LOG2_L_DEFAULT = 2;
    localparam int SAMPLE_W       = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/linear_interpolator_phase_calc.sv
// Combinational phase datapath: prev + floor(diff * phase / L).
// The product is taken at full width so that the arithmetic shift floors toward minus infinity.
module interp_phase_calc
    import linear_interpolator_pkg::*;
#(
    parameter int LOG2_L = LOG2_L_DEFAULT
) (
    input  logic signed [SAMPLE_W-1:0] prev,
    input  logic signed [SAMPLE_W:0]   diff,
    input  logic        [LOG2_L:0]     phase,
    output logic signed [SAMPLE_W-1:0] result
);

    localparam int PW = SAMPLE_W + 1 + LOG2_L;

    logic signed [PW-1:0] diff_ext;
    logic signed [PW-1:0] phase_ext;
    logic signed [PW-1:0] product;

    assign diff_ext  = PW'(diff);
    assign phase_ext = PW'({1'b0, phase});
    assign product   = diff_ext * phase_ext;

    // The true result lies between prev and the new sample, so wrapping 16-bit addition is exact.
    assign result = prev + SAMPLE_W'(product >>> LOG2_L);

endmodule

// File: rtl/linear_interpolator.sv
// Linear interpolating upsampler: each accepted sample yields L outputs stepping from the
// previous sample toward it, with a one-cycle IDLE bubble between bursts.
module linear_interpolator
    import linear_interpolator_pkg::*;
#(
    parameter int LOG2_L = LOG2_L_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam logic [LOG2_L:0]   PHASE_ONE = 1;
    localparam logic [LOG2_L-1:0] K_ONE     = 1;

    state_t                     state;
    logic signed [SAMPLE_W-1:0] prev;
    logic signed [SAMPLE_W-1:0] cur;
    logic signed [SAMPLE_W:0]   diff;
    logic        [LOG2_L-1:0]   k;
    logic        [LOG2_L:0]     next_phase;
    logic signed [SAMPLE_W-1:0] next_value;

    assign in_ready   = (state == IDLE);
    assign next_phase = {1'b0, k} + PHASE_ONE;

    interp_phase_calc #(
        .LOG2_L (LOG2_L)
    ) u_phase_calc (
        .prev   (prev),
        .diff   (diff),
        .phase  (next_phase),
        .result (next_value)
    );

    // L-1 is all ones, so the last phase is k == '1 for every legal LOG2_L.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prev      <= '0;
            cur       <= '0;
            diff      <= '0;
            k         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cur       <= in_data;
                        diff      <= (SAMPLE_W+1)'(in_data) - (SAMPLE_W+1)'(prev);
                        k         <= '0;
                        out_data  <= prev;
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (k == '1) begin
                            prev      <= cur;
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            k        <= k + K_ONE;
                            out_data <= next_value;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_interpolator.sv
// Self-checking bench for linear_interpolator: directed bursts, stalls, mid-burst reset,
// extreme values and random bursts, all checked against an arithmetic model of the output sequence.
module tb_linear_interpolator;

    localparam int LOG2_L = 2;
    localparam int L      = 1 << LOG2_L;

    logic               clk;
    logic               rst;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;

    int checks;
    int errors;
    longint model_prev;

    linear_interpolator #(
        .LOG2_L (LOG2_L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic longint expected_value(input longint p, input longint x, input int ph);
        return p + floor_div((x - p) * ph, L);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // One burst: accept x, then walk all L phases; forced_len stall cycles on forced_phase,
    // otherwise up to max_stall random stalls per phase, with junk in_valid while stalled.
    task automatic applyStimulus(input logic signed [15:0] x, input int max_stall,
                                 input int forced_phase, input int forced_len);
        int n;
        checkOutput("in_ready_before_accept", 32'(in_ready), 1);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        advance();
        in_valid = 1'b0;
        for (int ph = 0; ph < L; ph++) begin
            if (ph == forced_phase) n = forced_len;
            else if (max_stall > 0) n = int'($urandom_range(0, max_stall));
            else n = 0;
            for (int s = 0; s <= n; s++) begin
                checkOutput($sformatf("out_valid_ph%0d", ph), 32'(out_valid), 1);
                checkOutput($sformatf("out_data_ph%0d", ph), 32'(out_data),
                            32'(expected_value(model_prev, longint'(x), ph)));
                checkOutput($sformatf("in_ready_busy_ph%0d", ph), 32'(in_ready), 0);
                out_ready = (s == n);
                in_valid  = (s < n);
                in_data   = 16'($urandom);
                advance();
            end
        end
        in_valid = 1'b0;
        checkOutput("out_valid_after_burst", 32'(out_valid), 0);
        checkOutput("in_ready_after_burst", 32'(in_ready), 1);
        model_prev = longint'(x);
    endtask

    // Accept x, emit phases up to stop_phase, then reset while stop_phase is on the output.
    task automatic applyResetMidBurst(input logic signed [15:0] x, input int stop_phase);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b1;
        advance();
        in_valid = 1'b0;
        for (int ph = 0; ph < stop_phase; ph++) begin
            checkOutput($sformatf("pre_reset_ph%0d", ph), 32'(out_data),
                        32'(expected_value(model_prev, longint'(x), ph)));
            advance();
        end
        checkOutput("pre_reset_stop_phase", 32'(out_data),
                    32'(expected_value(model_prev, longint'(x), stop_phase)));
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checkOutput("reset_mid_out_valid", 32'(out_valid), 0);
        checkOutput("reset_mid_in_ready", 32'(in_ready), 1);
        checkOutput("reset_mid_out_data", 32'(out_data), 0);
        model_prev = 0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model_prev = 0;
        rst        = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;

        advance();
        advance();
        rst = 1'b0;
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_out_data", 32'(out_data), 0);
        checkOutput("reset_in_ready", 32'(in_ready), 1);

        // 0 then 100: 0,0,0,0 then 0,25,50,75
        applyStimulus(16'sd0, 0, -1, 0);
        applyStimulus(16'sd100, 0, -1, 0);
        // negative diff exercises the floor shift: 100,50,0,-50
        applyStimulus(-16'sd100, 0, -1, 0);
        // five-cycle stall in the middle of a burst
        applyStimulus(16'sd300, 0, 1, 5);
        // reset during phase 2, then 40 must interpolate from 0
        applyResetMidBurst(16'sd1000, 2);
        applyStimulus(16'sd40, 0, -1, 0);
        // full-scale swing without overflow
        applyStimulus(-16'sd32768, 0, -1, 0);
        applyStimulus(16'sd32767, 0, -1, 0);
        applyStimulus(-16'sd32768, 1, -1, 0);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(16'($urandom), 3, -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/linear_interpolator.md
LINEAR_INTERPOLATOR -- requirements
Module: linear_interpolator

Interface
REQ-001 SHALL have parameter LOG2_L, default 2: log2 of the upsampling factor L; L = 4 by default; legal range 1..4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 16 bits: input sample, signed two's complement.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a sample.
REQ-007 SHALL have port out_data, output, 16 bits: interpolated sample, signed two's complement, registered.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid, registered.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data.

Function
REQ-010 SHALL implement a two-state FSM with states IDLE and EMIT.
REQ-011 SHALL drive in_ready = 1 in IDLE and 0 in EMIT; it is a combinational decode of the state register.
REQ-012 SHALL accept a sample only when in_valid && in_ready; on acceptance it latches cur <= in_data and diff <= in_data - prev (17-bit signed), sets phase k <= 0, out_data <= prev, out_valid <= 1, and enters EMIT.
REQ-013 SHALL present the first output on the cycle after acceptance (latency 1 cycle) with value prev, where prev is the previously accepted sample, or 0 after reset.
REQ-014 SHALL hold out_data and out_valid stable in EMIT while out_ready = 0; there is no timeout.
REQ-015 In EMIT, when out_ready = 1 and k < L-1, SHALL set k <= k+1 and out_data <= prev + ((diff * (k+1)) >>> LOG2_L).
REQ-016 In EMIT, when out_ready = 1 and k = L-1, SHALL set prev <= cur, out_valid <= 0, and return to IDLE.
REQ-017 Output sequence per input x SHALL be prev + floor((x - prev) * k / L) for k = 0..L-1; the endpoint x is emitted as the k = 0 value of the next burst.
REQ-018 Arithmetic: diff is 17 bits signed; the product is 17+LOG2_L bits signed; the shift is arithmetic (floor toward minus infinity); the result is truncated to 16 bits. The result always lies between prev and x, so no saturation is needed.
REQ-019 Throughput SHALL be at most L outputs per L+1 cycles, with one bubble cycle in IDLE between bursts.
REQ-020 in_valid seen in EMIT SHALL be ignored, with no side effects; the upstream holds the sample until in_ready.
REQ-021 Phase counter k SHALL be LOG2_L bits wide; it never wraps inside a burst and is reset to 0 on every acceptance.

Reset
REQ-022 While rst = 1 at a clock edge, SHALL force state = IDLE, prev = 0, cur = 0, diff = 0, k = 0, out_data = 0, and out_valid = 0; in_ready is therefore 1 on the following cycle.
REQ-023 rst SHALL take priority over every handshake; a burst in progress at reset is discarded and its remaining phases are never emitted.

Structure
REQ-024 A shared package SHALL hold the LOG2_L default, the sample width constant (16), and the FSM state enumeration.
REQ-025 The datapath computing prev + ((diff * k) >>> LOG2_L) SHALL be a combinational sub-module named interp_phase_calc; the FSM, counter, and registers stay in linear_interpolator.

Verification
REQ-026 Reset then feed 0, then 100 with out_ready = 1: outputs 0,0,0,0, then 0,25,50,75; in_ready low for exactly 4 cycles per burst.
REQ-027 After 100 is accepted, feed -100: outputs 100,50,0,-50, confirming the floor shift on negative diff.
REQ-028 Drive out_ready low for 5 cycles mid-burst: out_data and out_valid held, no phase skipped, in_ready stays 0.
REQ-029 Assert rst during phase 2 of a burst: next cycle out_valid = 0, in_ready = 1; then feeding 40 yields 0,10,20,30, proving prev was cleared.
REQ-030 Feed -32768, then 32767: second burst outputs -32768,-16385,-1,16383, with no overflow.
